cpu_run_sequencer: RTL and testbench

- Sequences the 6502 RES and RDY lines from the software control levels held in the SPI-written control register at 0xE80F.
- Arbitrates the CPU bus between the running CPU and SPI bus-master requests.
- Stretches software reset to a guaranteed minimum width in CPU cycles.
- Grants the bus to SPI only after the CPU has actually stopped; the 6502 honours RDY only on read cycles.

---
 rtl/cpu_run_sequencer_if.sv | 26 ++
 rtl/cpu_run_sequencer.sv | 107 ++++++++++
 tb/tb_cpu_run_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_sequencer_if.sv
// CPU run-control bundle between the software control register, the SPI bus master and the 6502 pads.
`default_nettype none

interface cpu_run_sequencer_if;
  logic cpu_en_i;
  logic cpu_rw_i;
  logic ctl_res_i;
  logic ctl_ready_i;
  logic spi_req_i;
  logic spi_grant_o;
  logic cpu_res_o;
  logic cpu_ready_o;
  logic cpu_halted_o;

  modport master (
    output cpu_en_i, cpu_rw_i, ctl_res_i, ctl_ready_i, spi_req_i,
    input  spi_grant_o, cpu_res_o, cpu_ready_o, cpu_halted_o
  );

  modport slave (
    input  cpu_en_i, cpu_rw_i, ctl_res_i, ctl_ready_i, spi_req_i,
    output spi_grant_o, cpu_res_o, cpu_ready_o, cpu_halted_o
  );
endinterface

`default_nettype wire

// File: rtl/cpu_run_sequencer.sv
// 6502 RES/RDY sequencer: stretches software reset, stops the CPU on a read cycle
// and hands the bus to the SPI master only once the CPU is halted.
`default_nettype none

module cpu_run_sequencer #(
  parameter int RES_CYCLES = 8
) (
  input  wire logic           clk_i,
  input  wire logic           reset_n_i,
  cpu_run_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(RES_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2,
    ST_STOPPED  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             cpu_res_q, cpu_res_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             cpu_halted_q, cpu_halted_d;
  logic             spi_grant_q, spi_grant_d;
  logic             run_ok;

  // The CPU may only resume once SPI has both dropped its request and lost the grant.
  assign run_ok = bus.ctl_ready_i && !bus.spi_req_i && !spi_grant_q;

  always_comb begin
    res_cnt_d = res_cnt_q;
    if (bus.ctl_res_i) begin
      res_cnt_d = CNT_W'(RES_CYCLES);
    end else if (bus.cpu_en_i && (res_cnt_q != '0)) begin
      res_cnt_d = res_cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.ctl_res_i) begin
      state_d = ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (res_cnt_q == '0) begin
            state_d = run_ok ? ST_RUN : ST_STOPPED;
          end
        end
        ST_RUN: begin
          if (!bus.ctl_ready_i || bus.spi_req_i) begin
            state_d = ST_STOPPING;
          end
        end
        // RDY is ignored on write cycles, so wait for the first read to be stalled.
        ST_STOPPING: begin
          if (bus.cpu_en_i && bus.cpu_rw_i) begin
            state_d = ST_STOPPED;
          end
        end
        ST_STOPPED: begin
          if (run_ok) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RESET;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    cpu_res_d    = (state_d == ST_RESET);
    cpu_ready_d  = (state_d == ST_RUN);
    cpu_halted_d = (state_d == ST_RESET) || (state_d == ST_STOPPED);
    spi_grant_d  = spi_grant_q ? bus.spi_req_i : (cpu_halted_q && bus.spi_req_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_RESET;
      res_cnt_q    <= CNT_W'(RES_CYCLES);
      cpu_res_q    <= 1'b1;
      cpu_ready_q  <= 1'b0;
      cpu_halted_q <= 1'b1;
      spi_grant_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_cnt_q    <= res_cnt_d;
      cpu_res_q    <= cpu_res_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_halted_q <= cpu_halted_d;
      spi_grant_q  <= spi_grant_d;
    end
  end

  assign bus.cpu_res_o    = cpu_res_q;
  assign bus.cpu_ready_o  = cpu_ready_q;
  assign bus.cpu_halted_o = cpu_halted_q;
  assign bus.spi_grant_o  = spi_grant_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer: vector table applied through a scoreboard
// queue, plus hand-written asynchronous-reset sequences.
`default_nettype none

module tb_cpu_run_sequencer;
  localparam int RES_CYCLES = 8;

  // Expected output nibbles: {cpu_res, cpu_ready, cpu_halted, spi_grant}
  localparam logic [3:0] E_RESET = 4'b1010;
  localparam logic [3:0] E_RESG  = 4'b1011;
  localparam logic [3:0] E_RUN   = 4'b0100;
  localparam logic [3:0] E_STPG  = 4'b0000;
  localparam logic [3:0] E_HALT  = 4'b0010;
  localparam logic [3:0] E_HALTG = 4'b0011;

  typedef struct {
    string      name;
    logic       res;
    logic       rdy;
    logic       spi;
    logic       en;
    logic       rw;
    logic [3:0] exp;
  } vec_t;

  logic clk_i = 1'b0;
  logic reset_n_i;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  vec_t sb[$];

  cpu_run_sequencer_if bus ();

  cpu_run_sequencer #(.RES_CYCLES(RES_CYCLES)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] outs();
    return {bus.cpu_res_o, bus.cpu_ready_o, bus.cpu_halted_o, bus.spi_grant_o};
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: res/rdy/hlt/gnt got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add(input string name, input logic res, input logic rdy, input logic spi,
                     input logic en, input logic rw, input logic [3:0] exp);
    vec_t v;
    v.name = name; v.res = res; v.rdy = rdy; v.spi = spi; v.en = en; v.rw = rw; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk_i);
    bus.ctl_res_i   = v.res;
    bus.ctl_ready_i = v.rdy;
    bus.spi_req_i   = v.spi;
    bus.cpu_en_i    = v.en;
    bus.cpu_rw_i    = v.rw;
    sb.push_back(v);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check(e.name, outs(), e.exp);
  endtask

  task automatic drive(input string name, input logic res, input logic rdy, input logic spi,
                       input logic en, input logic rw, input logic [3:0] exp);
    vec_t v;
    v.name = name; v.res = res; v.rdy = rdy; v.spi = spi; v.en = en; v.rw = rw; v.exp = exp;
    apply(v);
  endtask

  initial begin
    // Reset release: eight strobes, then RUN one clock later
    add("rel_idle", 0, 1, 0, 0, 0, E_RESET);
    for (int i = 0; i < RES_CYCLES; i++) add("rel_strobe", 0, 1, 0, 1, 0, E_RESET);
    add("rel_run", 0, 1, 0, 0, 0, E_RUN);
    // Reset stretch from a one-clock pulse, strobes spaced by idle clocks
    add("str_pulse", 1, 1, 0, 0, 0, E_RESET);
    for (int i = 0; i < RES_CYCLES; i++) begin
      add("str_strobe", 0, 1, 0, 1, 0, E_RESET);
      add("str_gap", 0, 1, 0, 0, 0, (i == RES_CYCLES - 1) ? E_RUN : E_RESET);
    end
    // Halt only on the read strobe, grant one clock later
    add("halt_req", 0, 1, 1, 0, 0, E_STPG);
    add("halt_wait", 0, 1, 1, 0, 0, E_STPG);
    for (int i = 0; i < 3; i++) add("halt_wr", 0, 1, 1, 1, 0, E_STPG);
    add("halt_rd", 0, 1, 1, 1, 1, E_HALT);
    add("grant", 0, 1, 1, 0, 0, E_HALTG);
    add("grant_hold", 0, 1, 1, 1, 1, E_HALTG);
    // Grant release, then resume
    add("gnt_drop", 0, 1, 0, 0, 0, E_HALT);
    add("resume", 0, 1, 0, 0, 0, E_RUN);
    // Drop and re-raise request while stopped: regrant without resuming
    add("rg_req", 0, 1, 1, 0, 0, E_STPG);
    add("rg_rd", 0, 1, 1, 1, 1, E_HALT);
    add("rg_grant", 0, 1, 1, 0, 0, E_HALTG);
    add("rg_drop", 0, 1, 0, 0, 0, E_HALT);
    add("rg_again", 0, 1, 1, 0, 0, E_HALTG);
    add("rdy_low", 0, 0, 1, 0, 0, E_HALTG);
    add("rdy_rise", 0, 1, 1, 0, 0, E_HALTG);
    // Software reset while granted: grant survives until the request drops
    add("res_gnt", 1, 0, 1, 0, 0, E_RESG);
    add("res_gnt_hold", 1, 0, 1, 1, 0, E_RESG);
    for (int i = 0; i < RES_CYCLES; i++) begin
      add("res_gnt_strobe", 0, 0, (i < 4), 1, 0, (i < 4) ? E_RESG : E_RESET);
      add("res_gnt_gap", 0, 0, (i < 4), 0, 0,
          (i == RES_CYCLES - 1) ? E_HALT : ((i < 4) ? E_RESG : E_RESET));
    end
    add("post_res_run", 0, 1, 0, 0, 0, E_RUN);
    add("to_stopping", 0, 0, 0, 0, 0, E_STPG);

    bus.ctl_res_i   = 1'b0;
    bus.ctl_ready_i = 1'b1;
    bus.spi_req_i   = 1'b0;
    bus.cpu_en_i    = 1'b0;
    bus.cpu_rw_i    = 1'b0;
    reset_n_i       = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_state", outs(), E_RESET);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Asynchronous reset in STOPPING, checked before any clock edge
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_stopping", outs(), E_RESET);
    @(negedge clk_i);
    bus.ctl_ready_i = 1'b1;
    bus.spi_req_i   = 1'b1;
    @(posedge clk_i);
    #1;
    check("async_hold", outs(), E_RESET);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // Leaving reset with SPI pending goes to STOPPED, not RUN
    for (int i = 0; i < RES_CYCLES; i++) drive("rx_strobe", 0, 1, 1, 1, 0, E_RESG);
    drive("rx_exit", 0, 1, 1, 0, 0, E_HALTG);

    // Asynchronous reset revokes the grant
    @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    check("async_grant_drop", outs(), E_RESET);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    bus.spi_req_i = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
